// File: rtl/rv_pkg.sv
// Shared register-file widths and the write-request record used by the writeback path.
package rv_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/rv_wb_fifo.sv
// In-order load-response queue; each slot carries valid and kill bits, and a kill port
// marks every live slot whose rd matches.
module rv_wb_fifo import rv_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  output wb_req_t               head_req,
  output logic                  head_kill,
  output logic                  empty,
  output logic                  full,
  output logic                  busy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           wptr, rptr;
  wb_req_t               mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q, kill_q;

  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign head_req  = mem_q[rptr[AW-1:0]];
  assign head_kill = kill_q[rptr[AW-1:0]];
  assign busy      = |(vld_q & ~kill_q);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr   <= '0;
      rptr   <= '0;
      vld_q  <= '0;
      kill_q <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (kill_en && vld_q[i] && mem_q[i].rd == kill_rd) kill_q[i] <= 1'b1;
      if (pop) begin
        vld_q[rptr[AW-1:0]] <= 1'b0;
        rptr                <= rptr + 1'b1;
      end
      // The push slot is never live (no push when full), so it cannot race a kill.
      if (push) begin
        vld_q[wptr[AW-1:0]]  <= 1'b1;
        kill_q[wptr[AW-1:0]] <= 1'b0;
        wptr                 <= wptr + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk)
    if (push) mem_q[wptr[AW-1:0]] <= push_req;
endmodule

// File: rtl/rv_writeback.sv
// Merges ALU results and queued load responses onto the single register-file write port
// and forwards the just-written value over the register file's stale read.
module rv_writeback import rv_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  input  logic        i_mem_valid,
  output logic        o_mem_ready,
  input  logic [4:0]  i_mem_rd,
  input  logic [31:0] i_mem_data,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_rf_data1,
  input  logic [31:0] i_rf_data2,
  output logic [4:0]  o_rd,
  output logic        o_write,
  output logic [31:0] o_data,
  output logic [31:0] o_data1,
  output logic [31:0] o_data2,
  output logic        o_busy
);
  wb_req_t     head_req, mem_req;
  logic        head_kill, q_empty, q_full;
  logic        alu_wr, mem_hs, mem_use, pop, bypass, push;
  logic        nxt_write;
  logic [4:0]  nxt_rd;
  logic [31:0] nxt_data;
  logic        fwd_en1, fwd_en2;
  logic [31:0] fwd_data1, fwd_data2;

  assign o_mem_ready = !q_full;
  assign alu_wr      = i_alu_valid && (i_alu_rd != '0);
  assign mem_hs      = i_mem_valid && o_mem_ready;
  // A load to x0, or to the rd a younger ALU result writes this cycle, is swallowed.
  assign mem_use     = mem_hs && (i_mem_rd != '0) && !(alu_wr && i_alu_rd == i_mem_rd);
  assign pop         = !alu_wr && !q_empty;
  assign bypass      = !alu_wr && q_empty && mem_use;
  assign push        = mem_use && !bypass;
  assign mem_req     = '{rd: i_mem_rd, data: i_mem_data};

  rv_wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (push),
    .push_req  (mem_req),
    .pop       (pop),
    .kill_en   (alu_wr),
    .kill_rd   (i_alu_rd),
    .head_req  (head_req),
    .head_kill (head_kill),
    .empty     (q_empty),
    .full      (q_full),
    .busy      (o_busy)
  );

  always_comb begin
    nxt_write = 1'b0;
    nxt_rd    = o_rd;
    nxt_data  = o_data;
    if (alu_wr) begin
      nxt_write = 1'b1;
      nxt_rd    = i_alu_rd;
      nxt_data  = i_alu_data;
    end else if (pop) begin
      if (!head_kill) begin
        nxt_write = 1'b1;
        nxt_rd    = head_req.rd;
        nxt_data  = head_req.data;
      end
    end else if (bypass) begin
      nxt_write = 1'b1;
      nxt_rd    = i_mem_rd;
      nxt_data  = i_mem_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_write   <= 1'b0;
      o_rd      <= '0;
      o_data    <= '0;
      fwd_en1   <= 1'b0;
      fwd_en2   <= 1'b0;
      fwd_data1 <= '0;
      fwd_data2 <= '0;
    end else begin
      o_write   <= nxt_write;
      o_rd      <= nxt_rd;
      o_data    <= nxt_data;
      fwd_en1   <= o_write && (o_rd != '0) && (i_rs1 == o_rd);
      fwd_en2   <= o_write && (o_rd != '0) && (i_rs2 == o_rd);
      fwd_data1 <= o_data;
      fwd_data2 <= o_data;
    end
  end

  assign o_data1 = fwd_en1 ? fwd_data1 : i_rf_data1;
  assign o_data2 = fwd_en2 ? fwd_data2 : i_rf_data2;
endmodule

// File: tb/tb_rv_writeback.sv
// Directed bench for rv_writeback: a queue-level reference model checked every cycle,
// plus hand-computed expectations at each scenario step.
module tb_rv_writeback;
  import rv_pkg::*;
  localparam int DEPTH = 4;

  logic        i_clk = 1'b0, i_reset;
  logic        i_alu_valid, i_mem_valid, o_mem_ready, o_write, o_busy;
  logic [4:0]  i_alu_rd, i_mem_rd, i_rs1, i_rs2, o_rd;
  logic [31:0] i_alu_data, i_mem_data, i_rf_data1, i_rf_data2, o_data, o_data1, o_data2;

  rv_writeback #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready), .i_mem_rd(i_mem_rd), .i_mem_data(i_mem_data),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rf_data1(i_rf_data1), .i_rf_data2(i_rf_data2),
    .o_rd(o_rd), .o_write(o_write), .o_data(o_data),
    .o_data1(o_data1), .o_data2(o_data2), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Reference model: queue of pending loads, killed flag per entry.
  typedef struct { logic [4:0] rd; logic [31:0] data; bit dead; } ld_t;
  ld_t         mq[$];
  bit          m_on = 0, e_w = 0, e_f1 = 0, e_f2 = 0;
  logic [4:0]  e_rd = '0;
  logic [31:0] e_data = '0, e_fd1 = '0, e_fd2 = '0;

  always @(posedge i_clk) begin : model
    bit aw, hs, used, byp, wn;
    logic [4:0] rdn;
    logic [31:0] dn;
    ld_t h, e;
    m_on = 1;
    if (i_reset) begin
      mq.delete();
      e_w = 0; e_rd = '0; e_data = '0;
      e_f1 = 0; e_f2 = 0; e_fd1 = '0; e_fd2 = '0;
    end else begin
      e_f1  = e_w && e_rd != 0 && i_rs1 == e_rd;
      e_f2  = e_w && e_rd != 0 && i_rs2 == e_rd;
      e_fd1 = e_data;
      e_fd2 = e_data;
      hs   = i_mem_valid && mq.size() < DEPTH;
      aw   = i_alu_valid && i_alu_rd != 0;
      used = hs && i_mem_rd != 0 && !(aw && i_alu_rd == i_mem_rd);
      byp = 0; wn = 0; rdn = e_rd; dn = e_data;
      if (aw) begin
        foreach (mq[i]) if (mq[i].rd == i_alu_rd) mq[i].dead = 1;
        wn = 1; rdn = i_alu_rd; dn = i_alu_data;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        if (!h.dead) begin wn = 1; rdn = h.rd; dn = h.data; end
      end else if (used) begin
        byp = 1; wn = 1; rdn = i_mem_rd; dn = i_mem_data;
      end
      if (used && !byp) begin
        e.rd = i_mem_rd; e.data = i_mem_data; e.dead = 0;
        mq.push_back(e);
      end
      e_w = wn; e_rd = rdn; e_data = dn;
    end
  end

  always @(negedge i_clk) begin : compare
    bit busy_e;
    if (m_on) begin
      busy_e = 0;
      foreach (mq[i]) if (!mq[i].dead) busy_e = 1;
      chk("m_write", 32'(o_write), 32'(e_w));
      if (e_w) begin
        chk("m_rd", 32'(o_rd), 32'(e_rd));
        chk("m_data", o_data, e_data);
      end
      chk("m_ready", 32'(o_mem_ready), 32'(mq.size() < DEPTH));
      chk("m_busy", 32'(o_busy), 32'(busy_e));
      chk("m_data1", o_data1, e_f1 ? e_fd1 : i_rf_data1);
      chk("m_data2", o_data2, e_f2 ? e_fd2 : i_rf_data2);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_alu_valid = 0; i_alu_rd = 0; i_alu_data = 0;
    i_mem_valid = 0; i_mem_rd = 0; i_mem_data = 0;
    i_rs1 = 0; i_rs2 = 0; i_rf_data1 = 0; i_rf_data2 = 0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    i_alu_valid = 1; i_alu_rd = rd; i_alu_data = d;
  endtask

  task automatic mem(input logic [4:0] rd, input logic [31:0] d);
    i_mem_valid = 1; i_mem_rd = rd; i_mem_data = d;
  endtask

  logic [4:0]  lrd [5];
  int          idx;
  bit          hs;
  int          wr_rd[$];
  logic [31:0] wr_d[$];

  initial begin
    lrd = '{5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
    idle();
    // Reset with traffic on every input.
    i_reset = 1;
    alu(5'd5, 32'h1); mem(5'd6, 32'h2); i_rs1 = 5'd1; i_rs2 = 5'd1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_write", 32'(o_write), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_ready", 32'(o_mem_ready), 1);
    end
    i_reset = 0; idle();
    chk("rst_after_write", 32'(o_write), 0);
    tick();
    chk("rst_after2_write", 32'(o_write), 0);

    // ALU write and dropped x0 write.
    alu(5'd5, 32'h1234); tick();
    chk("alu_write", 32'(o_write), 1);
    chk("alu_rd", 32'(o_rd), 5);
    chk("alu_data", o_data, 32'h1234);
    alu(5'd0, 32'h55); tick();
    chk("alu_x0_write", 32'(o_write), 0);

    // ALU occupies the port; loads back up until the queue is full.
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      alu(5'd3, 32'h300 + c);
      mem(lrd[idx], 32'h1000 + 32'(lrd[idx]));
      hs = o_mem_ready;
      tick();
      if (hs) idx++;
    end
    chk("conf_accepted", 32'(idx), 4);
    chk("conf_ready", 32'(o_mem_ready), 0);
    chk("conf_busy", 32'(o_busy), 1);
    i_alu_valid = 0;
    for (int c = 0; c < 20 && wr_rd.size() < 5; c++) begin
      if (idx < 5) mem(lrd[idx], 32'h1000 + 32'(lrd[idx]));
      else i_mem_valid = 0;
      hs = i_mem_valid && o_mem_ready;
      tick();
      if (hs) idx++;
      if (o_write) begin wr_rd.push_back(o_rd); wr_d.push_back(o_data); end
    end
    i_mem_valid = 0;
    chk("drain_count", 32'(wr_rd.size()), 5);
    for (int k = 0; k < wr_rd.size() && k < 5; k++) begin
      chk("drain_rd", 32'(wr_rd[k]), 32'(lrd[k]));
      chk("drain_data", wr_d[k], 32'h1000 + 32'(lrd[k]));
    end

    // Queued load to x4 is killed by a younger ALU write to x4.
    idle(); tick();
    alu(5'd2, 32'h22); mem(5'd4, 32'hBB);
    chk("kill_ready", 32'(o_mem_ready), 1);
    tick();
    chk("kill_alu2_rd", 32'(o_rd), 2);
    chk("kill_busy_q", 32'(o_busy), 1);
    idle(); alu(5'd4, 32'hAA); tick();
    chk("kill_wr", 32'(o_write), 1);
    chk("kill_rd", 32'(o_rd), 4);
    chk("kill_data", o_data, 32'hAA);
    chk("kill_busy_dead", 32'(o_busy), 0);
    idle(); tick();
    chk("kill_pop_nowrite", 32'(o_write), 0);
    tick();
    chk("kill_after_nowrite", 32'(o_write), 0);

    // Same-cycle ALU and load to x6: only the ALU value lands.
    alu(5'd6, 32'h66); mem(5'd6, 32'h77);
    chk("same_ready", 32'(o_mem_ready), 1);
    tick();
    chk("same_rd", 32'(o_rd), 6);
    chk("same_data", o_data, 32'h66);
    chk("same_busy", 32'(o_busy), 0);
    idle(); tick();
    chk("same_nowrite", 32'(o_write), 0);

    // Bypass on an empty queue, then a swallowed x0 load.
    mem(5'd12, 32'hC0C0); tick();
    chk("byp_write", 32'(o_write), 1);
    chk("byp_rd", 32'(o_rd), 12);
    chk("byp_data", o_data, 32'hC0C0);
    chk("byp_busy", 32'(o_busy), 0);
    mem(5'd0, 32'h99); tick();
    chk("ld_x0_nowrite", 32'(o_write), 0);
    chk("ld_x0_busy", 32'(o_busy), 0);

    // Forwarding over the stale register-file read.
    idle(); alu(5'd9, 32'hDEAD); tick();
    idle(); i_rs1 = 5'd9; i_rs2 = 5'd9; tick();
    chk("fwd_data1", o_data1, 32'hDEAD);
    chk("fwd_data2", o_data2, 32'hDEAD);
    idle(); alu(5'd9, 32'hBEEF); tick();
    idle(); i_rs1 = 5'd0; i_rs2 = 5'd9; i_rf_data1 = 32'h11; i_rf_data2 = 32'h22; tick();
    chk("fwd_rs0_data1", o_data1, 32'h11);
    chk("fwd_rs2_data2", o_data2, 32'hBEEF);

    // Reset with loads queued: they are discarded.
    idle(); alu(5'd1, 32'h1); mem(5'd13, 32'hD13); tick();
    mem(5'd14, 32'hD14); tick();
    chk("mid_busy_pre", 32'(o_busy), 1);
    i_reset = 1; alu(5'd5, 32'h5); mem(5'd15, 32'hD15); tick();
    chk("mid_rst_write", 32'(o_write), 0);
    chk("mid_rst_busy", 32'(o_busy), 0);
    i_reset = 0; idle();
    chk("mid_after_write", 32'(o_write), 0);
    tick();
    chk("mid_after2_write", 32'(o_write), 0);
    tick();
    chk("mid_after3_write", 32'(o_write), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
